// File: rtl/vscale_hpm_pkg.sv
// Shared constants for the hardware performance monitor: CSR addresses,
// CSR command codes and the read-modify-write helper.
package vscale_hpm_pkg;

   // Each counter bank reserves 16 consecutive addresses; unused slots decode as undefined
   localparam logic [11:0] CNT_LO_BASE = 12'hB03;
   localparam logic [11:0] CNT_HI_BASE = 12'hB83;
   localparam logic [11:0] EVSEL_BASE  = 12'h323;
   localparam logic [11:0] INHIBIT     = 12'h320;
   localparam logic [11:0] OVF_STATUS  = 12'h7C0;
   localparam int unsigned BANK_SLOTS  = 16;

   localparam logic [2:0] CSR_IDLE  = 3'd0;
   localparam logic [2:0] CSR_READ  = 3'd4;
   localparam logic [2:0] CSR_WRITE = 3'd5;
   localparam logic [2:0] CSR_SET   = 3'd6;
   localparam logic [2:0] CSR_CLEAR = 3'd7;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_LO,
      SEL_HI,
      SEL_EVSEL,
      SEL_INHIBIT,
      SEL_OVF
   } hpm_sel_e;

   function automatic logic [31:0] csr_rmw(input logic [2:0]  cmd,
                                           input logic [31:0] rdata,
                                           input logic [31:0] wdata);
      if (cmd == CSR_SET)
         return rdata | wdata;
      else if (cmd == CSR_CLEAR)
         return rdata & ~wdata;
      else
         return wdata;
   endfunction

endpackage

// File: rtl/vscale_hpm_counter.sv
// One performance-counter channel: count register, event select, overflow
// interrupt enable, increment/wrap logic and the lo/hi software write ports.
module vscale_hpm_counter
   import vscale_hpm_pkg::*;
#(
   parameter int CNT_WIDTH  = 48,
   parameter int NUM_EVENTS = 8,
   parameter int EVSEL_W    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inhibit_i,
   input  logic [NUM_EVENTS-1:0] events_i,
   input  logic                  lo_we_i,
   input  logic                  hi_we_i,
   input  logic                  evsel_we_i,
   input  logic [31:0]           wdata_i,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  wrap_o,
   output logic [EVSEL_W-1:0]    evsel_o,
   output logic                  ovf_en_o
);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [EVSEL_W-1:0]   evsel_q, evsel_d;
   logic                 ovf_en_q, ovf_en_d;
   logic                 ev_hit;
   logic                 inc;

   // Selects beyond the event bus match no entry and therefore never count
   always_comb begin
      ev_hit = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++)
         if (int'(evsel_q) == e)
            ev_hit = events_i[e];
   end

   // A software write to either half pre-empts this cycle's increment
   assign inc    = !inhibit_i && ev_hit && !lo_we_i && !hi_we_i;
   assign wrap_o = inc && (&count_q);

   always_comb begin
      count_d  = count_q;
      evsel_d  = evsel_q;
      ovf_en_d = ovf_en_q;
      if (lo_we_i)
         count_d[31:0] = wdata_i;
      else if (hi_we_i)
         count_d[CNT_WIDTH-1:32] = wdata_i[CNT_WIDTH-33:0];
      else if (inc)
         count_d = count_q + CNT_WIDTH'(1);
      if (evsel_we_i) begin
         evsel_d  = wdata_i[EVSEL_W-1:0];
         ovf_en_d = wdata_i[31];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         evsel_q  <= '0;
         ovf_en_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         evsel_q  <= evsel_d;
         ovf_en_q <= ovf_en_d;
      end
   end

   assign count_o  = count_q;
   assign evsel_o  = evsel_q;
   assign ovf_en_o = ovf_en_q;

endmodule

// File: rtl/vscale_hpm_unit.sv
// Hardware performance monitor in CSR space: address decode, read mux,
// read-modify-write, global inhibit mask, sticky overflow status and irq.
module vscale_hpm_unit
   import vscale_hpm_pkg::*;
#(
   parameter int NUM_CNT    = 4,
   parameter int CNT_WIDTH  = 48,
   parameter int NUM_EVENTS = 8,
   parameter int EVSEL_W    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [11:0]           csr_addr,
   input  logic [2:0]            csr_cmd,
   input  logic [31:0]           csr_wdata,
   output logic [31:0]           csr_rdata,
   output logic                  csr_defined,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  ovf_irq
);

   logic [CNT_WIDTH-1:0] count [NUM_CNT];
   logic [EVSEL_W-1:0]   evsel [NUM_CNT];
   logic [NUM_CNT-1:0]   wrap;
   logic [NUM_CNT-1:0]   ovf_en;
   logic [NUM_CNT-1:0]   inhibit_q, inhibit_d;
   logic [NUM_CNT-1:0]   ovf_q, ovf_d;

   logic [11:0] lo_off, hi_off, ev_off;
   hpm_sel_e    sel;
   logic [3:0]  idx;
   logic        chan_ok;
   logic        wen;
   logic [31:0] wr;

   assign lo_off = csr_addr - CNT_LO_BASE;
   assign hi_off = csr_addr - CNT_HI_BASE;
   assign ev_off = csr_addr - EVSEL_BASE;

   always_comb begin
      sel = SEL_NONE;
      idx = '0;
      if (lo_off < 12'(BANK_SLOTS)) begin
         sel = SEL_LO;
         idx = lo_off[3:0];
      end else if (hi_off < 12'(BANK_SLOTS)) begin
         sel = SEL_HI;
         idx = hi_off[3:0];
      end else if (ev_off < 12'(BANK_SLOTS)) begin
         sel = SEL_EVSEL;
         idx = ev_off[3:0];
      end else if (csr_addr == INHIBIT) begin
         sel = SEL_INHIBIT;
      end else if (csr_addr == OVF_STATUS) begin
         sel = SEL_OVF;
      end
   end

   assign chan_ok     = int'(idx) < NUM_CNT;
   assign csr_defined = (sel == SEL_INHIBIT) || (sel == SEL_OVF) ||
                        (((sel == SEL_LO) || (sel == SEL_HI) || (sel == SEL_EVSEL)) && chan_ok);

   always_comb begin
      csr_rdata = '0;
      case (sel)
         SEL_INHIBIT: csr_rdata = 32'(inhibit_q);
         SEL_OVF:     csr_rdata = 32'(ovf_q);
         default: begin
            for (int i = 0; i < NUM_CNT; i++) begin
               if (int'(idx) == i) begin
                  case (sel)
                     SEL_LO:    csr_rdata = count[i][31:0];
                     SEL_HI:    csr_rdata = 32'(count[i][CNT_WIDTH-1:32]);
                     SEL_EVSEL: csr_rdata = 32'(evsel[i]) | {ovf_en[i], 31'b0};
                     default:   csr_rdata = '0;
                  endcase
               end
            end
         end
      endcase
   end

   // Undefined addresses never produce a write strobe, so they are silently ignored
   assign wen = csr_cmd[2] && (csr_cmd[1:0] != 2'b00) && csr_defined;
   assign wr  = csr_rmw(csr_cmd, csr_rdata, csr_wdata);

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      vscale_hpm_counter #(
         .CNT_WIDTH  (CNT_WIDTH),
         .NUM_EVENTS (NUM_EVENTS),
         .EVSEL_W    (EVSEL_W)
      ) u_counter (
         .clk        (clk),
         .reset      (reset),
         .inhibit_i  (inhibit_q[i]),
         .events_i   (events),
         .lo_we_i    (wen && (sel == SEL_LO)    && (int'(idx) == i)),
         .hi_we_i    (wen && (sel == SEL_HI)    && (int'(idx) == i)),
         .evsel_we_i (wen && (sel == SEL_EVSEL) && (int'(idx) == i)),
         .wdata_i    (wr),
         .count_o    (count[i]),
         .wrap_o     (wrap[i]),
         .evsel_o    (evsel[i]),
         .ovf_en_o   (ovf_en[i])
      );
   end

   // Hardware wrap is OR-ed in after the software write so a same-cycle clear loses
   always_comb begin
      inhibit_d = inhibit_q;
      ovf_d     = ovf_q;
      if (wen && (sel == SEL_INHIBIT))
         inhibit_d = wr[NUM_CNT-1:0];
      if (wen && (sel == SEL_OVF))
         ovf_d = wr[NUM_CNT-1:0];
      ovf_d = ovf_d | wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inhibit_q <= '1;
         ovf_q     <= '0;
      end else begin
         inhibit_q <= inhibit_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ovf_irq = |(ovf_q & ovf_en);

endmodule

// File: tb/tb_vscale_hpm_unit.sv
// Self-checking bench for vscale_hpm_unit: reset table, directed corner
// sequences and randomized traffic against a behavioural register model.
module tb_vscale_hpm_unit;
   import vscale_hpm_pkg::*;

   localparam int NC = 4;
   localparam int CW = 48;
   localparam int NE = 8;
   localparam int EW = 4;
   localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

   logic          clk = 1'b0;
   logic          reset;
   logic [11:0]   csr_addr;
   logic [2:0]    csr_cmd;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_rdata;
   logic          csr_defined;
   logic [NE-1:0] events;
   logic          ovf_irq;

   always #50 clk = ~clk;

   vscale_hpm_unit #(
      .NUM_CNT    (NC),
      .CNT_WIDTH  (CW),
      .NUM_EVENTS (NE),
      .EVSEL_W    (EW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .csr_addr    (csr_addr),
      .csr_cmd     (csr_cmd),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .csr_defined (csr_defined),
      .events      (events),
      .ovf_irq     (ovf_irq)
   );

   int passed = 0;
   int total  = 0;

   // Behavioural model: full-width counts as plain integers
   longint unsigned m_cnt [NC];
   logic [EW-1:0]   m_evs [NC];
   bit              m_en  [NC];
   logic [NC-1:0]   m_inh;
   logic [NC-1:0]   m_ovf;

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0;
         m_evs[i] = '0;
         m_en[i]  = 1'b0;
      end
      m_inh = '1;
      m_ovf = '0;
   endfunction

   function automatic void model_read(input logic [11:0] a, output bit def, output logic [31:0] rd);
      def = 1'b0;
      rd  = '0;
      for (int i = 0; i < NC; i++) begin
         if (a == 12'(CNT_LO_BASE + i)) begin
            def = 1'b1; rd = 32'(m_cnt[i] & 64'hFFFF_FFFF);
         end else if (a == 12'(CNT_HI_BASE + i)) begin
            def = 1'b1; rd = 32'(m_cnt[i] >> 32);
         end else if (a == 12'(EVSEL_BASE + i)) begin
            def = 1'b1; rd = 32'(m_evs[i]) | (m_en[i] ? 32'h8000_0000 : 32'h0);
         end
      end
      if (a == INHIBIT) begin
         def = 1'b1; rd = 32'(m_inh);
      end else if (a == OVF_STATUS) begin
         def = 1'b1; rd = 32'(m_ovf);
      end
   endfunction

   function automatic bit model_irq();
      bit r = 1'b0;
      for (int i = 0; i < NC; i++)
         if (m_ovf[i] && m_en[i]) r = 1'b1;
      return r;
   endfunction

   function automatic void model_cycle(input logic rst, input logic [11:0] a, input logic [2:0] c,
                                       input logic [31:0] wd, input logic [NE-1:0] ev);
      bit            def;
      bit            wen;
      logic [31:0]   rd, wr;
      logic [NC-1:0] wrapped = '0;
      if (rst) begin
         model_reset();
         return;
      end
      model_read(a, def, rd);
      wr  = (c == CSR_SET) ? (rd | wd) : (c == CSR_CLEAR) ? (rd & ~wd) : wd;
      wen = def && c[2] && (c[1:0] != 2'b00);
      for (int i = 0; i < NC; i++) begin
         if (wen && a == 12'(CNT_LO_BASE + i))
            m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(wr);
         else if (wen && a == 12'(CNT_HI_BASE + i))
            m_cnt[i] = ((64'(wr) << 32) & CMAX) | (m_cnt[i] & 64'hFFFF_FFFF);
         else if (!m_inh[i] && m_evs[i] < NE && ev[m_evs[i]]) begin
            if (m_cnt[i] == CMAX) begin
               m_cnt[i]   = 0;
               wrapped[i] = 1'b1;
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
         if (wen && a == 12'(EVSEL_BASE + i)) begin
            m_evs[i] = wr[EW-1:0];
            m_en[i]  = wr[31];
         end
      end
      if (wen && a == INHIBIT)
         m_inh = wr[NC-1:0];
      m_ovf = ((wen && a == OVF_STATUS) ? wr[NC-1:0] : m_ovf) | wrapped;
   endfunction

   task automatic step(input logic rst, input logic [11:0] a, input logic [2:0] c,
                       input logic [31:0] wd, input logic [NE-1:0] ev);
      reset     = rst;
      csr_addr  = a;
      csr_cmd   = c;
      csr_wdata = wd;
      events    = ev;
      @(posedge clk);
      model_cycle(rst, a, c, wd, ev);
      #1;
      reset   = 1'b0;
      csr_cmd = CSR_IDLE;
      events  = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk_reg(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a;
      csr_cmd  = CSR_READ;
      #1;
      chk(name, csr_rdata, exp);
      csr_cmd = CSR_IDLE;
   endtask

   task automatic chk_irq(input string name, input logic exp);
      #1;
      chk(name, {31'b0, ovf_irq}, {31'b0, exp});
   endtask

   task automatic chk_model(input logic [11:0] a);
      bit          d;
      logic [31:0] rd;
      model_read(a, d, rd);
      csr_addr = a;
      csr_cmd  = CSR_READ;
      #1;
      chk($sformatf("rd@%h", a), csr_rdata, rd);
      chk($sformatf("def@%h", a), {31'b0, csr_defined}, {31'b0, d});
      csr_cmd = CSR_IDLE;
   endtask

   typedef struct {
      logic [11:0] addr;
      logic [31:0] rdata;
      logic        def;
   } rvec_t;

   rvec_t rtab [17];

   task automatic run_reset_table(input string tag);
      for (int k = 0; k < 17; k++) begin
         csr_addr = rtab[k].addr;
         csr_cmd  = CSR_READ;
         #1;
         chk($sformatf("%s_rd%0d", tag, k), csr_rdata, rtab[k].rdata);
         chk($sformatf("%s_def%0d", tag, k), {31'b0, csr_defined}, {31'b0, rtab[k].def});
      end
      csr_cmd = CSR_IDLE;
      chk_irq({tag, "_irq"}, 1'b0);
   endtask

   function automatic logic [11:0] rand_addr();
      int r = $urandom_range(0, 5);
      case ($urandom_range(0, 4))
         0:       return 12'(CNT_LO_BASE + r);
         1:       return 12'(CNT_HI_BASE + r);
         2:       return 12'(EVSEL_BASE + r);
         3:       return INHIBIT;
         default: return OVF_STATUS;
      endcase
   endfunction

   initial begin
      logic [2:0]  cmds [5] = '{CSR_IDLE, CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR};
      logic [11:0] a;
      logic [2:0]  c;
      logic [31:0] wd;

      for (int i = 0; i < NC; i++) begin
         rtab[i]        = '{12'(CNT_LO_BASE + i), 32'h0, 1'b1};
         rtab[NC + i]   = '{12'(CNT_HI_BASE + i), 32'h0, 1'b1};
         rtab[2*NC + i] = '{12'(EVSEL_BASE + i),  32'h0, 1'b1};
      end
      rtab[12] = '{INHIBIT,                 32'hF, 1'b1};
      rtab[13] = '{OVF_STATUS,              32'h0, 1'b1};
      rtab[14] = '{12'(CNT_LO_BASE + 4),    32'h0, 1'b0};
      rtab[15] = '{12'(CNT_HI_BASE + 7),    32'h0, 1'b0};
      rtab[16] = '{12'(EVSEL_BASE + 15),    32'h0, 1'b0};

      reset = 1'b1; csr_addr = '0; csr_cmd = CSR_IDLE; csr_wdata = '0; events = '0;
      model_reset();
      step(1'b1, 12'h0, CSR_IDLE, 32'h0, '0);
      step(1'b1, 12'h0, CSR_IDLE, 32'h0, '0);
      run_reset_table("reset");

      // Event select and basic counting
      step(1'b0, EVSEL_BASE, CSR_WRITE, 32'd2, '0);
      step(1'b0, INHIBIT, CSR_WRITE, 32'd0, '0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h04);
         step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h00);
      end
      for (int k = 0; k < 3; k++)
         step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h02);
      chk_reg("cnt0_five", CNT_LO_BASE, 32'd5);
      for (int i = 1; i < NC; i++)
         chk_reg($sformatf("cnt%0d_idle", i), 12'(CNT_LO_BASE + i), 32'd0);

      // Wrap, sticky status and interrupt
      step(1'b0, CNT_HI_BASE, CSR_WRITE, 32'h0000_FFFF, '0);
      step(1'b0, CNT_LO_BASE, CSR_WRITE, 32'hFFFF_FFFE, '0);
      step(1'b0, EVSEL_BASE, CSR_WRITE, 32'h8000_0002, '0);
      step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h04);
      chk_reg("pre_wrap_lo", CNT_LO_BASE, 32'hFFFF_FFFF);
      chk_reg("pre_wrap_ovf", OVF_STATUS, 32'h0);
      chk_irq("pre_wrap_irq", 1'b0);
      step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h04);
      chk_reg("wrap_lo", CNT_LO_BASE, 32'h0);
      chk_reg("wrap_hi", CNT_HI_BASE, 32'h0);
      chk_reg("wrap_ovf", OVF_STATUS, 32'h1);
      chk_irq("wrap_irq", 1'b1);
      step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h00);
      chk_irq("irq_held", 1'b1);
      step(1'b0, OVF_STATUS, CSR_CLEAR, 32'h1, 8'h00);
      chk_reg("ovf_cleared", OVF_STATUS, 32'h0);
      chk_irq("irq_dropped", 1'b0);

      // Write beats a coincident event; inhibit takes effect one cycle later
      step(1'b0, 12'(EVSEL_BASE + 1), CSR_WRITE, 32'd3, '0);
      step(1'b0, 12'(CNT_LO_BASE + 1), CSR_WRITE, 32'd100, 8'h08);
      chk_reg("write_wins", 12'(CNT_LO_BASE + 1), 32'd100);
      step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h04);
      chk_reg("cnt0_one", CNT_LO_BASE, 32'd1);
      step(1'b0, INHIBIT, CSR_SET, 32'h1, 8'h04);
      chk_reg("inh_old_mask", CNT_LO_BASE, 32'd2);
      step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'h04);
      chk_reg("inh_frozen", CNT_LO_BASE, 32'd2);
      chk_reg("inh_value", INHIBIT, 32'h1);

      // Hardware wrap beats a same-cycle software clear
      step(1'b0, 12'(EVSEL_BASE + 2), CSR_WRITE, 32'd5, '0);
      step(1'b0, 12'(CNT_HI_BASE + 2), CSR_WRITE, 32'h0000_FFFF, '0);
      step(1'b0, 12'(CNT_LO_BASE + 2), CSR_WRITE, 32'hFFFF_FFFF, '0);
      step(1'b0, OVF_STATUS, CSR_CLEAR, 32'h4, 8'h20);
      chk_reg("hw_set_wins", OVF_STATUS, 32'h4);
      chk_reg("cnt2_wrapped", 12'(CNT_LO_BASE + 2), 32'h0);
      chk_irq("irq_masked", 1'b0);
      step(1'b0, OVF_STATUS, CSR_CLEAR, 32'h4, 8'h00);
      chk_reg("ovf2_cleared", OVF_STATUS, 32'h0);

      // Out-of-range event select never counts
      step(1'b0, 12'(EVSEL_BASE + 3), CSR_WRITE, 32'd9, '0);
      step(1'b0, INHIBIT, CSR_WRITE, 32'd0, '0);
      for (int k = 0; k < 5; k++)
         step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'hFF);
      chk_reg("evsel9_reads", 12'(EVSEL_BASE + 3), 32'd9);
      chk_reg("evsel9_nocount", 12'(CNT_LO_BASE + 3), 32'd0);

      // Reset mid-count discards the pending write
      step(1'b0, 12'h0, CSR_IDLE, 32'h0, 8'hFF);
      step(1'b1, CNT_LO_BASE, CSR_WRITE, 32'd1234, 8'hFF);
      run_reset_table("midreset");

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         a  = rand_addr();
         c  = cmds[$urandom_range(0, 4)];
         wd = $urandom;
         if (a >= CNT_HI_BASE && a < 12'(CNT_HI_BASE + NC) && $urandom_range(0, 1) == 1)
            wd = 32'h0000_FFFF;
         if (a >= CNT_LO_BASE && a < 12'(CNT_LO_BASE + NC) && $urandom_range(0, 1) == 1)
            wd = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         step(($urandom_range(0, 299) == 0), a, c, wd, NE'($urandom));
         chk_model(rand_addr());
         chk_irq("rand_irq", model_irq());
      end
      for (int k = 0; k < 17; k++)
         chk_model(rtab[k].addr);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
